// File: rtl/rx_sync_pkg.sv
// Shared definitions for the receive-lane word-sync controller: comma code,
// word/counter widths and FSM state encoding.
package rx_sync_pkg;

    localparam int unsigned WORD_W   = 8;
    localparam int unsigned LOSS_W   = 8;
    localparam logic [WORD_W-1:0] COMMA_BC = 8'hBC;

    // 2'b11 is not a legal state; the FSM recovers from it to HUNT.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'b00,
        ST_ALIGN  = 2'b01,
        ST_LOCKED = 2'b10
    } rx_state_e;

    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] data;
    } rx_word_t;

    function automatic logic is_comma(input logic [WORD_W-1:0] w);
        return (w == COMMA_BC);
    endfunction

endpackage

// File: rtl/sync_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sync_sat_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != {WIDTH{1'b1}})) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rx_sync_ctrl.sv
// Word-sync controller: hunts for a run of K28.5 commas, forwards payload once
// locked, drops back to hunt on keep-alive gap violations and counts the drops.
module rx_sync_ctrl
    import rx_sync_pkg::*;
#(
    parameter int unsigned BC_LOCK = 4,
    parameter int unsigned MAX_GAP = 16
) (
    input  logic              clk_4f,
    input  logic              reset_L,
    input  logic              enable,
    input  logic [WORD_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              locked,
    output logic [1:0]        state_out,
    output logic [LOSS_W-1:0] sync_loss_cnt
);

    localparam int unsigned BC_W  = (BC_LOCK > 1) ? $clog2(BC_LOCK + 1) : 1;
    localparam int unsigned GAP_W = $clog2(MAX_GAP + 1);

    rx_state_e          r_state, w_nxt_state;
    logic [BC_W-1:0]    r_bc_cnt, w_nxt_bc_cnt;
    logic [GAP_W-1:0]   r_gap_cnt, w_nxt_gap_cnt;
    rx_word_t           r_out, w_nxt_out;
    logic               r_locked;
    logic               w_loss_inc;
    logic               w_is_bc;

    assign w_is_bc = is_comma(data_in);

    // State, counters and output registers.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            r_state   <= ST_HUNT;
            r_bc_cnt  <= '0;
            r_gap_cnt <= '0;
            r_out     <= '0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_bc_cnt  <= w_nxt_bc_cnt;
            r_gap_cnt <= w_nxt_gap_cnt;
            r_out     <= w_nxt_out;
            r_locked  <= (w_nxt_state == ST_LOCKED);
        end
    end

    // Next-state, counter and output decode; enable has priority over data.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_bc_cnt   = r_bc_cnt;
        w_nxt_gap_cnt  = r_gap_cnt;
        w_nxt_out      = r_out;
        w_nxt_out.valid = 1'b0;
        w_loss_inc     = 1'b0;

        if (!enable) begin
            w_nxt_state   = ST_HUNT;
            w_nxt_bc_cnt  = '0;
            w_nxt_gap_cnt = '0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (data_in_valid && w_is_bc) begin
                        if (BC_LOCK == 1) begin
                            w_nxt_state   = ST_LOCKED;
                            w_nxt_bc_cnt  = '0;
                            w_nxt_gap_cnt = '0;
                        end else begin
                            w_nxt_state  = ST_ALIGN;
                            w_nxt_bc_cnt = BC_W'(1);
                        end
                    end
                end
                ST_ALIGN: begin
                    if (data_in_valid) begin
                        if (!w_is_bc) begin
                            w_nxt_state  = ST_HUNT;
                            w_nxt_bc_cnt = '0;
                        end else if (r_bc_cnt >= BC_W'(BC_LOCK - 1)) begin
                            w_nxt_state   = ST_LOCKED;
                            w_nxt_bc_cnt  = '0;
                            w_nxt_gap_cnt = '0;
                        end else begin
                            w_nxt_bc_cnt = r_bc_cnt + BC_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (data_in_valid) begin
                        if (w_is_bc) begin
                            w_nxt_gap_cnt = '0;
                        end else if (r_gap_cnt < GAP_W'(MAX_GAP)) begin
                            w_nxt_gap_cnt   = r_gap_cnt + GAP_W'(1);
                            w_nxt_out.valid = 1'b1;
                        end else begin
                            w_nxt_state   = ST_HUNT;
                            w_nxt_gap_cnt = '0;
                            w_loss_inc    = 1'b1;
                        end
                    end
                end
                default: begin
                    w_nxt_state   = ST_HUNT;
                    w_nxt_bc_cnt  = '0;
                    w_nxt_gap_cnt = '0;
                end
            endcase

            if (data_in_valid) begin
                w_nxt_out.data = data_in;
            end
        end
    end

    sync_sat_cnt #(
        .WIDTH (LOSS_W)
    ) u_loss_cnt (
        .i_clk   (clk_4f),
        .i_rst_n (reset_L),
        .i_inc   (w_loss_inc),
        .i_clr   (1'b0),
        .o_q     (sync_loss_cnt)
    );

    assign data_out  = r_out.data;
    assign valid_out = r_out.valid;
    assign locked    = r_locked;
    assign state_out = r_state;

endmodule

// File: tb/tb_rx_sync_ctrl.sv
// Directed self-checking bench for rx_sync_ctrl with hand-computed expectations.
module tb_rx_sync_ctrl;

    logic       clk_4f = 1'b0;
    logic       reset_L;
    logic       enable;
    logic [7:0] data_in;
    logic       data_in_valid;
    logic [7:0] data_out;
    logic       valid_out;
    logic       locked;
    logic [1:0] state_out;
    logic [7:0] sync_loss_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int pulses;

    always #5 clk_4f = ~clk_4f;

    rx_sync_ctrl dut (
        .clk_4f        (clk_4f),
        .reset_L       (reset_L),
        .enable        (enable),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .locked        (locked),
        .state_out     (state_out),
        .sync_loss_cnt (sync_loss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply one word at the falling edge, return 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk_4f);
        data_in       = d;
        data_in_valid = v;
        @(posedge clk_4f);
        #1;
    endtask

    task automatic lock4();
        for (int i = 0; i < 4; i++) drive(1'b1, 8'hBC);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, 32'(state_out), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_valid"}, 32'(valid_out), 32'd0);
        check({tag, "_data"}, 32'(data_out), 32'd0);
        check({tag, "_loss"}, 32'(sync_loss_cnt), 32'd0);
    endtask

    initial begin
        reset_L       = 1'b0;
        enable        = 1'b0;
        data_in       = 8'h00;
        data_in_valid = 1'b0;
        #1;
        check_zero("por");
        repeat (3) @(posedge clk_4f);
        @(negedge clk_4f);
        reset_L = 1'b1;
        enable  = 1'b1;

        // Lock on 4 commas, then two payload words.
        check("t2_st0", 32'(state_out), 32'd0);
        drive(1'b1, 8'hBC); check("t2_st1", 32'(state_out), 32'd1);
        check("t2_lk1", 32'(locked), 32'd0);
        drive(1'b1, 8'hBC); check("t2_st2", 32'(state_out), 32'd1);
        drive(1'b1, 8'hBC); check("t2_st3", 32'(state_out), 32'd1);
        drive(1'b1, 8'hBC); check("t2_st4", 32'(state_out), 32'd2);
        check("t2_lk4", 32'(locked), 32'd1);
        check("t2_v4", 32'(valid_out), 32'd0);
        drive(1'b1, 8'h12);
        check("t2_v12", 32'(valid_out), 32'd1);
        check("t2_d12", 32'(data_out), 32'h12);
        drive(1'b1, 8'h34);
        check("t2_v34", 32'(valid_out), 32'd1);
        check("t2_d34", 32'(data_out), 32'h34);

        // Asynchronous reset mid-stream, held across active words.
        data_in = 8'h56;
        @(posedge clk_4f);
        #3;
        reset_L = 1'b0;
        #1;
        check_zero("t1_async");
        drive(1'b1, 8'hBC);
        drive(1'b1, 8'h77);
        check_zero("t1_hold");
        @(negedge clk_4f);
        reset_L = 1'b1;

        // Broken comma run restarts the hunt.
        drive(1'b1, 8'hBC); check("t3_st1", 32'(state_out), 32'd1);
        drive(1'b1, 8'hBC); check("t3_st2", 32'(state_out), 32'd1);
        drive(1'b1, 8'h55); check("t3_st3", 32'(state_out), 32'd0);
        check("t3_lk3", 32'(locked), 32'd0);
        drive(1'b1, 8'hBC); check("t3_st4", 32'(state_out), 32'd1);
        drive(1'b1, 8'hBC);
        drive(1'b1, 8'hBC); check("t3_st6", 32'(state_out), 32'd1);
        check("t3_lk6", 32'(locked), 32'd0);
        drive(1'b1, 8'hBC); check("t3_st7", 32'(state_out), 32'd2);
        check("t3_lk7", 32'(locked), 32'd1);
        check("t3_loss", 32'(sync_loss_cnt), 32'd0);

        // Gap supervision: 16 + BC + 16 tolerated, then 17th non-BC drops lock.
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i + 1));
            pulses += int'(valid_out);
        end
        drive(1'b1, 8'hBC);
        check("t4_bc_v", 32'(valid_out), 32'd0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i + 8'h20));
            pulses += int'(valid_out);
        end
        check("t4_pulses", 32'(pulses), 32'd32);
        check("t4_lk", 32'(locked), 32'd1);
        drive(1'b1, 8'hBC);
        for (int i = 0; i < 16; i++) drive(1'b1, 8'h40);
        check("t4_v16", 32'(valid_out), 32'd1);
        check("t4_lk16", 32'(locked), 32'd1);
        drive(1'b1, 8'h41);
        check("t4_v17", 32'(valid_out), 32'd0);
        check("t4_d17", 32'(data_out), 32'h41);
        check("t4_st17", 32'(state_out), 32'd0);
        check("t4_lk17", 32'(locked), 32'd0);
        check("t4_loss", 32'(sync_loss_cnt), 32'd1);

        // Idle cycles between payload words do not advance the gap count.
        lock4();
        check("t5_lk", 32'(locked), 32'd1);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(8'h60 + i));
            check("t5_v", 32'(valid_out), 32'd1);
            check("t5_d", 32'(data_out), 32'(8'h60 + i));
            drive(1'b0, 8'hEE);
            check("t5_idle_v", 32'(valid_out), 32'd0);
            check("t5_idle_d", 32'(data_out), 32'(8'h60 + i));
        end
        check("t5_lk16", 32'(state_out), 32'd2);
        drive(1'b1, 8'h99);
        check("t5_v17", 32'(valid_out), 32'd0);
        check("t5_st17", 32'(state_out), 32'd0);
        check("t5_loss", 32'(sync_loss_cnt), 32'd2);

        // Saturate the loss counter.
        for (int n = 0; n < 253; n++) begin
            lock4();
            for (int i = 0; i < 17; i++) drive(1'b1, 8'h11);
        end
        check("t6_loss255", 32'(sync_loss_cnt), 32'hFF);
        lock4();
        for (int i = 0; i < 17; i++) drive(1'b1, 8'h11);
        check("t6_sat", 32'(sync_loss_cnt), 32'hFF);
        check("t6_st", 32'(state_out), 32'd0);

        // Disable while locked: back to HUNT, count untouched.
        lock4();
        drive(1'b1, 8'h22);
        check("t6_pre_v", 32'(valid_out), 32'd1);
        @(negedge clk_4f);
        enable        = 1'b0;
        data_in       = 8'h33;
        data_in_valid = 1'b1;
        @(posedge clk_4f);
        #1;
        check("t6_dis_st", 32'(state_out), 32'd0);
        check("t6_dis_lk", 32'(locked), 32'd0);
        check("t6_dis_v", 32'(valid_out), 32'd0);
        check("t6_dis_loss", 32'(sync_loss_cnt), 32'hFF);
        drive(1'b1, 8'hBC);
        check("t6_dis_bc", 32'(state_out), 32'd0);
        @(negedge clk_4f);
        enable = 1'b1;
        drive(1'b1, 8'hBC);
        check("t6_en_st", 32'(state_out), 32'd1);
        check("t6_en_loss", 32'(sync_loss_cnt), 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
